// File: rtl/domdup_pkg.sv
// domdup_pkg: shared widths and mode encoding for the sample packer.
package domdup_pkg;
   localparam int SAMPLE_WIDTH  = 10;
   localparam int WORD_WIDTH    = 16;
   localparam int GROUP_SAMPLES = 8;
   localparam int GROUP_WORDS   = 5;
   localparam int ACC_WIDTH     = 26;
   localparam int FILL_WIDTH    = 5;
   localparam int IDX_WIDTH     = $clog2(GROUP_SAMPLES);
   typedef enum logic {MODE_PASS = 1'b0, MODE_PACK = 1'b1} mode_e;
endpackage

// File: rtl/sample_packer.sv
// sample_packer: packs 10-bit samples into 16-bit words (8 samples -> 5 words) or passes them through.
module sample_packer
   import domdup_pkg::*;
(
   input  logic                    clock,
   input  logic                    reset,
   input  logic [SAMPLE_WIDTH-1:0] sampleIn,
   input  logic                    sampleValid,
   input  logic                    packMode,
   input  logic                    resync,
   output logic [WORD_WIDTH-1:0]   dataOut,
   output logic                    dataValid,
   output logic                    groupStart
);
   logic [ACC_WIDTH-1:0]  acc_q, acc_d, acc_ext;
   logic [FILL_WIDTH-1:0] fill_q, fill_d, fill_sum;
   logic [IDX_WIDTH-1:0]  idx_q, idx_d;
   mode_e                 mode_q, mode_d, cur_mode;
   logic [WORD_WIDTH-1:0] data_q, data_d;
   logic                  valid_q, valid_d, gs_q, gs_d, emit;

   always_comb begin
      // packMode only takes effect when no partial group is in flight
      cur_mode = (idx_q == '0) ? mode_e'(packMode) : mode_q;
      acc_ext  = acc_q | (ACC_WIDTH'(sampleIn) << fill_q);
      fill_sum = fill_q + FILL_WIDTH'(SAMPLE_WIDTH);
      emit     = fill_sum >= FILL_WIDTH'(WORD_WIDTH);
      acc_d    = acc_q;
      fill_d   = fill_q;
      idx_d    = idx_q;
      mode_d   = mode_q;
      data_d   = data_q;
      valid_d  = 1'b0;
      gs_d     = 1'b0;
      if (resync) begin
         acc_d  = '0;
         fill_d = '0;
         idx_d  = '0;
         mode_d = mode_e'(packMode);
      end else if (sampleValid) begin
         mode_d = cur_mode;
         if (cur_mode == MODE_PASS) begin
            data_d  = WORD_WIDTH'(sampleIn);
            valid_d = 1'b1;
            gs_d    = 1'b1;
         end else begin
            idx_d   = idx_q + IDX_WIDTH'(1);
            acc_d   = emit ? acc_ext >> WORD_WIDTH : acc_ext;
            fill_d  = emit ? fill_sum - FILL_WIDTH'(WORD_WIDTH) : fill_sum;
            data_d  = emit ? acc_ext[WORD_WIDTH-1:0] : data_q;
            valid_d = emit;
            gs_d    = emit && (idx_q == IDX_WIDTH'(1));
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         acc_q   <= '0;
         fill_q  <= '0;
         idx_q   <= '0;
         mode_q  <= MODE_PASS;
         data_q  <= '0;
         valid_q <= 1'b0;
         gs_q    <= 1'b0;
      end else begin
         acc_q   <= acc_d;
         fill_q  <= fill_d;
         idx_q   <= idx_d;
         mode_q  <= mode_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         gs_q    <= gs_d;
      end
   end

   assign dataOut    = data_q;
   assign dataValid  = valid_q;
   assign groupStart = gs_q;
endmodule

// File: tb/tb_sample_packer.sv
// tb_sample_packer: directed vectors with hand-computed words for sample_packer.
module tb_sample_packer;
   logic        clock = 1'b0;
   logic        reset, sampleValid, packMode, resync;
   logic [9:0]  sampleIn;
   logic [15:0] dataOut;
   logic        dataValid, groupStart;
   int          vectors = 0, miscompares = 0, words = 0;
   logic [15:0] last_d = '0;
   logic [15:0] ref_words [5] = '{16'h0801, 16'h0030, 16'h0501, 16'h7018, 16'h0200};
   logic [7:0]  emit_mask = 8'b1101_1010;

   sample_packer dut (
      .clock(clock), .reset(reset), .sampleIn(sampleIn), .sampleValid(sampleValid),
      .packMode(packMode), .resync(resync), .dataOut(dataOut), .dataValid(dataValid),
      .groupStart(groupStart)
   );

   always #5 clock = ~clock;

   task automatic drive(input logic rst, input logic v, input logic [9:0] s, input logic m, input logic rs);
      @(negedge clock);
      reset = rst; sampleValid = v; sampleIn = s; packMode = m; resync = rs;
      @(posedge clock);
      #1;
   endtask

   task automatic chk(input string tag, input logic [15:0] d, input logic v, input logic g);
      vectors++;
      assert ({dataOut, dataValid, groupStart} === {d, v, g}) else begin
         miscompares++;
         $error("FAIL %s: got data=%h valid=%b gs=%b, expected data=%h valid=%b gs=%b",
                tag, dataOut, dataValid, groupStart, d, v, g);
      end
      if (v) last_d = d;
   endtask

   // one packed group of samples 1..8; packMode drops to 0 from sample index sw onward
   task automatic run_ref(input string tag, input int sw);
      int w = 0;
      for (int k = 0; k < 8; k++) begin
         drive(1'b0, 1'b1, 10'(k + 1), (k < sw), 1'b0);
         if (emit_mask[k]) begin
            chk(tag, ref_words[w], 1'b1, w == 0);
            w++;
         end else chk(tag, last_d, 1'b0, 1'b0);
      end
   endtask

   initial begin
      drive(1'b1, 1'b0, 10'h0, 1'b0, 1'b0);
      drive(1'b1, 1'b0, 10'h0, 1'b0, 1'b0);
      chk("reset", 16'h0000, 1'b0, 1'b0);
      drive(1'b0, 1'b1, 10'h2A5, 1'b0, 1'b0);
      chk("pass", 16'h02A5, 1'b1, 1'b1);
      drive(1'b0, 1'b0, 10'h3FF, 1'b0, 1'b0);
      chk("idle_hold", 16'h02A5, 1'b0, 1'b0);
      run_ref("pack_ref", 8);
      for (int i = 0; i < 16; i++) begin
         drive(1'b0, 1'b1, 10'h3FF, 1'b1, 1'b0);
         if (emit_mask[i % 8]) begin
            chk("ones_word", 16'hFFFF, 1'b1, (i % 8) == 1);
            words++;
         end else chk("ones_nowd", last_d, 1'b0, 1'b0);
         drive(1'b0, 1'b0, 10'h000, 1'b1, 1'b0);
         chk("ones_idle", last_d, 1'b0, 1'b0);
      end
      vectors++;
      assert (words === 10) else begin
         miscompares++;
         $error("FAIL ones_count: got %0d, expected 10", words);
      end
      run_ref("after_ones", 8);
      drive(1'b0, 1'b1, 10'h155, 1'b1, 1'b0);
      chk("rs_s0", last_d, 1'b0, 1'b0);
      drive(1'b0, 1'b1, 10'h155, 1'b1, 1'b0);
      chk("rs_s1", 16'h5555, 1'b1, 1'b1);
      drive(1'b0, 1'b1, 10'h155, 1'b1, 1'b0);
      chk("rs_s2", 16'h5555, 1'b0, 1'b0);
      drive(1'b0, 1'b1, 10'h3FF, 1'b1, 1'b1);
      chk("resync", 16'h5555, 1'b0, 1'b0);
      run_ref("post_resync", 8);
      run_ref("mode_mid", 4);
      drive(1'b0, 1'b1, 10'h123, 1'b0, 1'b0);
      chk("mode_bound", 16'h0123, 1'b1, 1'b1);
      drive(1'b0, 1'b1, 10'h001, 1'b1, 1'b0);
      chk("rst_s0", 16'h0123, 1'b0, 1'b0);
      drive(1'b0, 1'b1, 10'h002, 1'b1, 1'b0);
      chk("rst_s1", 16'h0801, 1'b1, 1'b1);
      drive(1'b0, 1'b1, 10'h003, 1'b1, 1'b0);
      chk("rst_s2", 16'h0801, 1'b0, 1'b0);
      drive(1'b1, 1'b1, 10'h3FF, 1'b1, 1'b1);
      chk("rst_mid", 16'h0000, 1'b0, 1'b0);
      drive(1'b0, 1'b1, 10'h0AB, 1'b0, 1'b0);
      chk("rst_pass", 16'h00AB, 1'b1, 1'b1);
      drive(1'b0, 1'b1, 10'h3C0, 1'b0, 1'b0);
      chk("rst_pass2", 16'h03C0, 1'b1, 1'b1);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
